stack_mem_responder: RTL

Memory-side responder for the stack processor's word memory. Accepts read/write requests from the core over a valid/ready handshake and returns exactly one in-order response per request after a fixed two-cycle pipeline. Response backpressure is absorbed by a small response FIFO. The block replaces direct array indexing of main memory by the core.

---
 rtl/stack_pkg.sv | 28 ++
 rtl/resp_fifo.sv | 46 ++++
 rtl/stack_mem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Definitions shared by the stack processor core and its word-memory responder.
package stack_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_PUSH  = 4'h1,
      OP_POP   = 4'h2,
      OP_DUP   = 4'h3,
      OP_SWAP  = 4'h4,
      OP_ADD   = 4'h5,
      OP_SUB   = 4'h6,
      OP_AND   = 4'h7,
      OP_OR    = 4'h8,
      OP_XOR   = 4'h9,
      OP_LOAD  = 4'hA,
      OP_STORE = 4'hB,
      OP_JMP   = 4'hC,
      OP_JZ    = 4'hD,
      OP_HALT  = 4'hF
   } opcode_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO holding responses; pointers carry an extra wrap bit so full and empty differ.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr[PTR_W-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head  = storage[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/stack_mem_responder.sv
// Word-memory responder: accepts load/store requests and returns one in-order response
// per request, two cycles after acceptance when the response path is clear.
module stack_mem_responder #(
   parameter int    ADDR_W     = stack_pkg::ADDR_W,
   parameter int    DATA_W     = stack_pkg::WORD_W,
   parameter int    FIFO_DEPTH = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_data
);

   import stack_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid and its payload stay stable until that edge, and ready never looks at valid.

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic              accept;
   logic              consume;
   logic              s1_valid;
   logic              s1_write;
   logic [DATA_W-1:0] s1_data;
   logic [CNT_W-1:0]  outstanding;
   logic [DATA_W:0]   fifo_head;
   logic              fifo_empty;
   logic              fifo_full;

   assign req_ready = !reset && (outstanding < CNT_W'(FIFO_DEPTH));
   assign accept    = req_valid && req_ready;
   assign consume   = rsp_valid && rsp_ready;

   // Memory is never reset; a store is committed at its accept edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (req_write) begin
            mem[req_addr] <= req_wdata;
            s1_data       <= req_wdata;
         end else begin
            s1_data       <= mem[req_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_write <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_write <= req_write;
      end
   end

   // Counts stage-1 plus FIFO occupancy, so a stage-1 push can never meet a full FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
      end else if (accept && !consume) begin
         outstanding <= outstanding + 1'b1;
      end else if (consume && !accept) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_resp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (s1_valid),
      .push_data ({s1_write, s1_data}),
      .pop       (consume),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_write = rsp_valid ? fifo_head[DATA_W] : 1'b0;
   assign rsp_data  = rsp_valid ? fifo_head[DATA_W-1:0] : '0;

   no_push_into_full: assert property (@(posedge clk) disable iff (reset)
      s1_valid |-> !fifo_full);

endmodule
